// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Parametrised 2R/1W register file (x0 hardwired to zero) with an
//            integrated issue/writeback scoreboard and read-hazard outputs.
//            Define REGFILE_BYPASS_EN for write-first read bypass.
// Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [AW-1:0]   rna,
    input  logic [AW-1:0]   rnb,
    output logic [XLEN-1:0] qa,
    output logic [XLEN-1:0] qb,
    input  logic [XLEN-1:0] d,
    input  logic [AW-1:0]   wn,
    input  logic            we,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    input  logic            sb_flush,
    output logic            hz_a,
    output logic            hz_b,
    output logic [NREG-1:0] busy
);

    localparam logic [AW:0] c_nreg = (AW+1)'(NREG);

    logic [XLEN-1:0] r_regs [NREG-1:1];
    logic [NREG-1:1] r_busy;

    logic            w_we_ok;
    logic [XLEN-1:0] w_qa;
    logic [XLEN-1:0] w_qb;
    logic            w_hz_a;
    logic            w_hz_b;

    assign w_we_ok = we && (wn != '0) && ({1'b0, wn} < c_nreg);

    // Issue is applied after writeback-clear so the younger producer wins.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_we_ok && (wn == AW'(i))) begin
                    r_regs[i] <= d;
                end
                if (sb_flush) begin
                    r_busy[i] <= 1'b0;
                end else if (iss_v && (iss_rd == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (we && (wn == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Out-of-range and zero addresses match no entry and fall through to 0.
    always_comb begin
        w_qa   = '0;
        w_qb   = '0;
        w_hz_a = 1'b0;
        w_hz_b = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (rna == AW'(i)) begin
                w_qa   = r_regs[i];
                w_hz_a = r_busy[i];
            end
            if (rnb == AW'(i)) begin
                w_qb   = r_regs[i];
                w_hz_b = r_busy[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (w_we_ok && (wn == rna)) begin
            w_qa = d;
        end
        if (w_we_ok && (wn == rnb)) begin
            w_qb = d;
        end
        if (we && (wn == rna)) begin
            w_hz_a = 1'b0;
        end
        if (we && (wn == rnb)) begin
            w_hz_b = 1'b0;
        end
`endif
    end

    assign qa   = w_qa;
    assign qb   = w_qb;
    assign hz_a = w_hz_a;
    assign hz_b = w_hz_b;
    assign busy = {r_busy, 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// Testbench for regfile_sb: directed steps plus random traffic against a
// behavioural array/scoreboard model; also a 64-bit/16-register instance.
module tb_regfile_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32x32 instance
    logic        clrn, we, iss_v, sb_flush;
    logic [4:0]  rna, rnb, wn, iss_rd;
    logic [31:0] d, qa, qb, busy;
    logic        hz_a, hz_b;

    // 64-bit, 16-register instance
    logic        p_clrn, p_we, p_iss_v, p_sb_flush;
    logic [4:0]  p_rna, p_rnb, p_wn, p_iss_rd;
    logic [63:0] p_d, p_qa, p_qb;
    logic [15:0] p_busy;
    logic        p_hz_a, p_hz_b;

    regfile_sb u_dut (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .d(d), .wn(wn), .we(we), .iss_v(iss_v), .iss_rd(iss_rd),
        .sb_flush(sb_flush), .hz_a(hz_a), .hz_b(hz_b), .busy(busy)
    );

    regfile_sb #(.XLEN(64), .NREG(16), .AW(5)) u_dut64 (
        .clk(clk), .clrn(p_clrn), .rna(p_rna), .rnb(p_rnb), .qa(p_qa), .qb(p_qb),
        .d(p_d), .wn(p_wn), .we(p_we), .iss_v(p_iss_v), .iss_rd(p_iss_rd),
        .sb_flush(p_sb_flush), .hz_a(p_hz_a), .hz_b(p_hz_b), .busy(p_busy)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    int errs   = 0;
    int checks = 0;

    // Reference model for the 32x32 instance
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_q(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (c_byp && we && wn == a) return d;
        return m_reg[a];
    endfunction

    function automatic logic exp_hz(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (c_byp && we && wn == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        v[0] = 1'b0;
        return v;
    endfunction

    task automatic model_edge();
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wn != 0) m_reg[wn] = d;
            if (sb_flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (we) m_busy[wn] = 1'b0;
                if (iss_v && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".qa"},   {32'h0, qa},   {32'h0, exp_q(rna)});
        chk({tag, ".qb"},   {32'h0, qb},   {32'h0, exp_q(rnb)});
        chk({tag, ".hz_a"}, {63'h0, hz_a}, {63'h0, exp_hz(rna)});
        chk({tag, ".hz_b"}, {63'h0, hz_b}, {63'h0, exp_hz(rnb)});
        chk({tag, ".busy"}, {32'h0, busy}, {32'h0, exp_busy()});
    endtask

    // Inputs are set just after an edge; this advances through the next edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; iss_v = 0; sb_flush = 0; clrn = 1;
        p_we = 0; p_iss_v = 0; p_sb_flush = 0; p_clrn = 1;
    endtask

    initial begin
        clrn = 0; we = 0; iss_v = 0; sb_flush = 0;
        rna = 0; rnb = 0; wn = 0; iss_rd = 0; d = 0;
        p_clrn = 0; p_we = 0; p_iss_v = 0; p_sb_flush = 0;
        p_rna = 0; p_rnb = 0; p_wn = 0; p_iss_rd = 0; p_d = 0;
        #1;
        tick();

        // 1: reset state
        idle(); rna = 5; rnb = 31; #3;
        chk("rst.qa", {32'h0, qa}, 64'h0);
        chk("rst.qb", {32'h0, qb}, 64'h0);
        chk("rst.hz", {62'h0, hz_a, hz_b}, 64'h0);
        chk("rst.busy", {32'h0, busy}, 64'h0);
        check_all("rst");
        tick();

        // 2: write/read, x0 guard
        we = 1; wn = 7; d = 32'hDEADBEEF; rna = 0; rnb = 0; #3; check_all("w7");
        tick();
        idle(); rna = 7; #3;
        chk("rd7", {32'h0, qa}, 64'hDEADBEEF);
        tick();
        we = 1; wn = 0; d = 32'h1234; tick();
        idle(); rna = 0; #3;
        chk("rd0", {32'h0, qa}, 64'h0);
        tick();

        // 3: same-cycle write/read
        we = 1; wn = 9; d = 32'hA5A5A5A5; rna = 9; #3;
        chk("byp.qa", {32'h0, qa}, c_byp ? 64'hA5A5A5A5 : 64'h0);
        check_all("byp");
        tick();

        // 4: scoreboard life cycle
        idle(); iss_v = 1; iss_rd = 12; rna = 12; #3; check_all("iss12");
        tick();
        idle(); rna = 12; #3;
        chk("busy12", {63'h0, busy[12]}, 64'h1);
        chk("hz12", {63'h0, hz_a}, 64'h1);
        we = 1; wn = 12; d = 32'h0C0C0C0C; #3;
        chk("hz12.wb", {63'h0, hz_a}, {63'h0, !c_byp});
        tick();
        idle(); rna = 12; #3;
        chk("busy12.clr", {63'h0, busy[12]}, 64'h0);
        chk("hz12.clr", {63'h0, hz_a}, 64'h0);
        tick();

        // 5: simultaneous issue/writeback, then flush with issue
        iss_v = 1; iss_rd = 3; tick();
        idle(); iss_v = 1; iss_rd = 3; we = 1; wn = 3; d = 32'h33333333; #3;
        check_all("iw3");
        tick();
        idle(); rna = 3; #3;
        chk("busy3", {63'h0, busy[3]}, 64'h1);
        chk("rd3", {32'h0, qa}, 64'h33333333);
        sb_flush = 1; iss_v = 1; iss_rd = 4; tick();
        idle(); #3;
        chk("flush", {32'h0, busy}, 64'h0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            clrn     = ($urandom_range(0, 63) != 0);
            we       = $urandom_range(0, 1);
            wn       = 5'($urandom);
            d        = $urandom;
            iss_v    = $urandom_range(0, 1);
            iss_rd   = 5'($urandom);
            sb_flush = ($urandom_range(0, 15) == 0);
            rna      = $urandom_range(0, 3) == 0 ? wn : 5'($urandom);
            rnb      = $urandom_range(0, 3) == 0 ? iss_rd : 5'($urandom);
            #3;
            check_all("rand");
            tick();
        end
        idle();

        // 6: 64-bit, 16-register instance
        p_we = 1; p_wn = 15; p_d = 64'hFFFF_0000_1234_5678; tick();
        p_we = 0; p_rna = 15; p_rnb = 20; #3;
        chk("p.rd15", p_qa, 64'hFFFF_0000_1234_5678);
        chk("p.rd20", p_qb, 64'h0);
        p_rna = 20; #3;
        chk("p.rna20", p_qa, 64'h0);
        p_iss_v = 1; p_iss_rd = 20; tick();
        p_iss_v = 0; #3;
        chk("p.iss20", {48'h0, p_busy}, 64'h0);
        p_iss_v = 1; p_iss_rd = 15; tick();
        p_iss_v = 0; p_rna = 15; #3;
        chk("p.busy15", {48'h0, p_busy}, 64'h8000);
        chk("p.hz15", {63'h0, p_hz_a}, 64'h1);
        p_we = 1; p_wn = 16; p_d = 64'h1; tick();
        p_we = 0; #3;
        chk("p.wr16", {48'h0, p_busy}, 64'h8000);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
